// File: rtl/signal_delay_pkg.sv
// Shared definitions for the signal_delay_line block.
// Optional bypass path is enabled with the SIGNAL_DELAY_BYPASS_EN macro.
package signal_delay_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Width of the occupancy counter: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Stage record at the default width; stages carry {valid, data}.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/signal_delay_if.sv
// Bus bundle for signal_delay_line: input side, control, registered output side.
// The bypass signal exists only when SIGNAL_DELAY_BYPASS_EN is defined.
interface signal_delay_if
    import signal_delay_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] in0;
    logic             in_valid;
    logic             hold;
    logic             flush;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [CW-1:0]    count;
`ifdef SIGNAL_DELAY_BYPASS_EN
    logic             bypass;
`endif

    modport master (
        output in0, in_valid, hold, flush,
`ifdef SIGNAL_DELAY_BYPASS_EN
        output bypass,
`endif
        input  out, out_valid, count
    );

    modport slave (
        input  in0, in_valid, hold, flush,
`ifdef SIGNAL_DELAY_BYPASS_EN
        input  bypass,
`endif
        output out, out_valid, count
    );
endinterface

// File: rtl/signal_delay_line_delay_stage.sv
// One {valid, data} register of the delay line with async reset, flush and hold.
module delay_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } rec_t;

    rec_t q;

    // Priority: reset > flush > hold > load from previous stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (flush)
            q <= '0;
        else if (!hold)
            q <= '{valid: d_valid, data: d_data};
    end

    assign q_valid = q.valid;
    assign q_data  = q.data;
endmodule

// File: rtl/signal_delay_line.sv
// Fixed-latency registered delay line: DEPTH stages of {valid, data} plus an
// occupancy count. Optional combinational bypass via SIGNAL_DELAY_BYPASS_EN.
module signal_delay_line
    import signal_delay_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic           clk,
    input logic           rst,
    signal_delay_if.slave bus
);
    localparam int CW = count_width(DEPTH);

    // Index 0 is the input; index i+1 is the output of stage i.
    logic [DEPTH:0]            vld;
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [CW-1:0]             count;

    assign vld[0] = bus.in_valid;
    assign dat[0] = bus.in0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        delay_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .hold    (bus.hold),
            .flush   (bus.flush),
            .d_valid (vld[i]),
            .d_data  (dat[i]),
            .q_valid (vld[i+1]),
            .q_data  (dat[i+1])
        );
    end

    // Occupancy: +1 on valid entry, -1 on valid exit (pre-edge final valid).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (bus.flush)
            count <= '0;
        else if (!bus.hold)
            count <= count + CW'(bus.in_valid) - CW'(vld[DEPTH]);
    end

    assign bus.count = count;

`ifdef SIGNAL_DELAY_BYPASS_EN
    // Bypass restores the plain wire; stages and count keep running underneath.
    assign bus.out       = bus.bypass ? bus.in0      : dat[DEPTH];
    assign bus.out_valid = bus.bypass ? bus.in_valid : vld[DEPTH];
`else
    assign bus.out       = dat[DEPTH];
    assign bus.out_valid = vld[DEPTH];
`endif
endmodule

// File: tb/tb_signal_delay_line.sv
// Directed test of signal_delay_line at WIDTH=8, DEPTH=4.
// Bypass checks are compiled in only with SIGNAL_DELAY_BYPASS_EN.
module tb_signal_delay_line;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    signal_delay_if #(.WIDTH(8), .DEPTH(4)) bus ();

    signal_delay_line #(.WIDTH(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int d, input int v, input int c);
        chk({tag, ".out"},       int'(bus.out),       d);
        chk({tag, ".out_valid"}, int'(bus.out_valid), v);
        chk({tag, ".count"},     int'(bus.count),     c);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.in0 = '0;
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
        bus.flush = 1'b0;
`ifdef SIGNAL_DELAY_BYPASS_EN
        bus.bypass = 1'b0;
`endif
        step();
        step();
        chk_out("por", 0, 0, 0);
        rst = 1'b0;

        // Fill with 0x55 so the reset below has something to clear.
        bus.in0 = 8'h55;
        bus.in_valid = 1'b1;
        repeat (4) step();
        chk_out("prefill", 8'h55, 1, 4);

        // Asynchronous reset mid-stream, sampled without a clock edge.
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0);
        step();
        chk_out("rst_held", 0, 0, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        // Single 0xA5 through the line: out after 4 edges.
        bus.in0 = 8'hA5;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in0 = 8'h00;
        chk_out("a5_e1", 0, 0, 1);
        step();
        step();
        chk("a5_e3.valid", int'(bus.out_valid), 0);
        chk("a5_e3.count", int'(bus.count), 1);
        step();
        chk_out("a5_e4", 8'hA5, 1, 1);
        step();
        chk("a5_e5.valid", int'(bus.out_valid), 0);
        chk("a5_e5.count", int'(bus.count), 0);

        // Back-to-back stream 1..6, then drain.
        for (int i = 1; i <= 6; i++) begin
            bus.in0 = 8'(i);
            bus.in_valid = 1'b1;
            step();
            chk($sformatf("strm%0d.count", i), int'(bus.count), (i < 4) ? i : 4);
            if (i >= 4) begin
                chk($sformatf("strm%0d.out", i), int'(bus.out), i - 3);
                chk($sformatf("strm%0d.valid", i), int'(bus.out_valid), 1);
            end
        end
        bus.in_valid = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            step();
            chk($sformatf("drain%0d.count", k), int'(bus.count), 10 - k);
            chk($sformatf("drain%0d.valid", k), int'(bus.out_valid), (k <= 9) ? 1 : 0);
            if (k <= 9)
                chk($sformatf("drain%0d.out", k), int'(bus.out), k - 3);
        end

        // Hold: 0x10..0x12 in flight, 0xFF offered while held must be dropped.
        // Stage data still carries the trailing 0x06 from the drain.
        for (int i = 0; i < 3; i++) begin
            bus.in0 = 8'(8'h10 + i);
            bus.in_valid = 1'b1;
            step();
        end
        bus.hold = 1'b1;
        bus.in0 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("hold%0d", i), 8'h06, 0, 3);
        end
        bus.hold = 1'b0;
        bus.in_valid = 1'b0;
        bus.in0 = 8'h00;
        step();
        chk_out("resume0", 8'h10, 1, 3);
        step();
        chk_out("resume1", 8'h11, 1, 2);
        step();
        chk_out("resume2", 8'h12, 1, 1);
        step();
        chk("resume3.valid", int'(bus.out_valid), 0);
        chk("resume3.count", int'(bus.count), 0);

        // Flush beats hold, and drops the 0x77 offered alongside.
        for (int i = 0; i < 4; i++) begin
            bus.in0 = 8'(8'h21 + i);
            bus.in_valid = 1'b1;
            step();
        end
        chk_out("full", 8'h21, 1, 4);
        bus.flush = 1'b1;
        bus.hold = 1'b1;
        bus.in0 = 8'h77;
        step();
        chk_out("flush", 0, 0, 0);
        bus.flush = 1'b0;
        bus.hold = 1'b0;
        bus.in_valid = 1'b0;
        bus.in0 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_flush%0d.valid", i), int'(bus.out_valid), 0);
            chk($sformatf("post_flush%0d.count", i), int'(bus.count), 0);
        end

        // Bubbles: valid 1,0,1,0 with data 1..4.
        for (int i = 1; i <= 4; i++) begin
            bus.in0 = 8'(i);
            bus.in_valid = (i % 2 == 1);
            step();
            chk($sformatf("bub_in%0d.count", i), int'(bus.count), (i < 3) ? 1 : 2);
        end
        chk_out("bub_e4", 8'h01, 1, 2);
        bus.in_valid = 1'b0;
        bus.in0 = 8'h00;
        step();
        chk_out("bub_e5", 8'h02, 0, 1);
        step();
        chk_out("bub_e6", 8'h03, 1, 1);
        step();
        chk_out("bub_e7", 8'h04, 0, 0);

`ifdef SIGNAL_DELAY_BYPASS_EN
        // Bypass: combinational wire, while the stages still capture the value.
        bus.bypass = 1'b1;
        bus.in0 = 8'h3C;
        bus.in_valid = 1'b1;
        #1;
        chk("byp.out", int'(bus.out), 8'h3C);
        chk("byp.valid", int'(bus.out_valid), 1);
        step();
        bus.bypass = 1'b0;
        bus.in_valid = 1'b0;
        bus.in0 = 8'h00;
        #1;
        chk_out("byp_e1", 8'h00, 0, 1);
        step();
        step();
        step();
        chk_out("byp_e4", 8'h3C, 1, 1);
        step();
        chk("byp_e5.count", int'(bus.count), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
